// File: rtl/dma_pkg.sv
// Shared types and constants for the DDR DMA read path.
package dma_pkg;

  localparam logic [2:0] APP_CMD_RD = 3'b001;
  localparam logic [2:0] APP_CMD_WR = 3'b000;

  // Channel index field sized for the largest supported channel count (32).
  localparam int CH_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            last;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_fifo.sv
// Synchronous tag FIFO; its occupancy is the outstanding-read count.
module rd_tag_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  rd_tag_t                wr_data,
  input  logic                   pop,
  output rd_tag_t                rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  rd_tag_t          mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && (count_r != (PTR_W+1)'(DEPTH));
  assign pop_ok_s  = pop && (count_r != (PTR_W+1)'(0));

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign empty   = (count_r == (PTR_W+1)'(0));
  assign full    = (count_r == (PTR_W+1)'(DEPTH));
  assign count   = count_r;

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin read-request arbiter that issues one app read per beat and
// routes in-order read returns back to the owning channel.
module ddr_rd_arbiter
  import dma_pkg::*;
#(
  parameter int N_CH       = 16,
  parameter int ADDR_W     = 27,
  parameter int LEN_W      = 27,
  parameter int DATA_W     = 512,
  parameter int APP_ADDR_W = 30,
  parameter int ADDR_SHIFT = 3,
  parameter int MAX_OUT    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_calib_complete,
  input  logic [N_CH-1:0]        rd_req,
  input  logic [N_CH*ADDR_W-1:0] rd_start_addr,
  input  logic [N_CH*LEN_W-1:0]  rd_length,
  output logic [N_CH-1:0]        rd_ack,
  output logic [APP_ADDR_W-1:0]  app_addr,
  output logic [2:0]             app_cmd,
  output logic                   app_en,
  input  logic                   app_rdy,
  input  logic [DATA_W-1:0]      app_rd_data,
  input  logic                   app_rd_data_valid,
  output logic [DATA_W-1:0]      dout,
  output logic [N_CH-1:0]        dout_en,
  output logic                   dout_eop,
  output logic                   rd_underflow
);

  localparam int CNT_W = $clog2(MAX_OUT) + 1;
  localparam int EXT_W = ADDR_W + ADDR_SHIFT + APP_ADDR_W;

  function automatic logic [APP_ADDR_W-1:0] beat_to_app(input logic [ADDR_W-1:0] a);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(a) << ADDR_SHIFT;
    return ext[APP_ADDR_W-1:0];
  endfunction

  function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [N_CH-1:0] one;
    one = {{(N_CH-1){1'b0}}, 1'b1};
    return one << ch;
  endfunction

  rd_state_e         state_r;
  rd_state_e         state_nxt_s;
  logic [CH_W-1:0]   rr_ptr_r;
  logic [CH_W-1:0]   cur_ch_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [LEN_W-1:0]  remaining_r;

  logic [2*N_CH-1:0] req_dbl_s;
  logic [N_CH-1:0]   req_rot_s;
  logic [CH_W-1:0]   grant_off_s;
  logic [CH_W:0]     grant_sum_s;
  logic [CH_W-1:0]   grant_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [LEN_W-1:0]  sel_len_s;
  logic              load_s;

  logic              push_s;
  logic              pop_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [CNT_W-1:0]  out_cnt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              credit_s;
  rd_tag_t           push_tag_s;
  rd_tag_t           pop_tag_s;

  // Rotate requests so the search starts at rr_ptr, then map back to a channel.
  always_comb begin
    req_dbl_s   = {rd_req, rd_req} >> rr_ptr_r;
    req_rot_s   = req_dbl_s[N_CH-1:0];
    grant_off_s = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot_s[k]) begin
        grant_off_s = CH_W'(k);
      end else begin
        grant_off_s = grant_off_s;
      end
    end
    grant_sum_s = {1'b0, rr_ptr_r} + {1'b0, grant_off_s};
    if (grant_sum_s >= (CH_W+1)'(N_CH)) begin
      grant_s = CH_W'(grant_sum_s - (CH_W+1)'(N_CH));
    end else begin
      grant_s = grant_sum_s[CH_W-1:0];
    end
    sel_addr_s = '0;
    sel_len_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_s == CH_W'(i)) begin
        sel_addr_s = rd_start_addr[i*ADDR_W +: ADDR_W];
        sel_len_s  = rd_length[i*LEN_W +: LEN_W];
      end else begin
        sel_addr_s = sel_addr_s;
        sel_len_s  = sel_len_s;
      end
    end
  end

  assign load_s     = (state_r == ST_IDLE) && init_calib_complete && (|rd_req);
  assign push_s     = app_en && app_rdy && !fifo_full_s;
  assign pop_s      = app_rd_data_valid && !fifo_empty_s;
  assign push_tag_s = '{ch: cur_ch_r, last: (remaining_r == LEN_W'(1))};

  // Occupancy after this edge decides whether another command may be offered.
  always_comb begin
    cnt_nxt_s = out_cnt_s;
    if (push_s && !pop_s) begin
      cnt_nxt_s = out_cnt_s + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      cnt_nxt_s = out_cnt_s - CNT_W'(1);
    end else begin
      cnt_nxt_s = out_cnt_s;
    end
    credit_s = (cnt_nxt_s < CNT_W'(MAX_OUT));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (remaining_r == LEN_W'(0)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (push_s && (remaining_r == LEN_W'(1))) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant capture and command issue; app_en/app_addr hold while the port stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      cur_ch_r    <= '0;
      cur_addr_r  <= '0;
      remaining_r <= '0;
      rd_ack      <= '0;
      app_en      <= 1'b0;
      app_addr    <= '0;
      app_cmd     <= APP_CMD_RD;
    end else begin
      rd_ack  <= '0;
      app_cmd <= APP_CMD_RD;
      case (state_r)
        ST_IDLE: begin
          app_en <= 1'b0;
          if (load_s) begin
            cur_ch_r    <= grant_s;
            cur_addr_r  <= sel_addr_s;
            remaining_r <= sel_len_s;
            rd_ack      <= ch_onehot(grant_s);
            rr_ptr_r    <= (grant_s == CH_W'(N_CH - 1)) ? '0 : grant_s + CH_W'(1);
          end
        end
        ST_LOAD: begin
          app_en   <= (remaining_r != LEN_W'(0)) && credit_s;
          app_addr <= beat_to_app(cur_addr_r);
        end
        ST_ISSUE: begin
          if (push_s) begin
            cur_addr_r  <= cur_addr_r + ADDR_W'(1);
            remaining_r <= remaining_r - LEN_W'(1);
            app_addr    <= beat_to_app(cur_addr_r + ADDR_W'(1));
            app_en      <= (remaining_r != LEN_W'(1)) && credit_s;
          end else if (!app_en) begin
            app_en <= credit_s;
          end else begin
            app_en <= app_en;
          end
        end
        default: app_en <= 1'b0;
      endcase
    end
  end

  // Return path: route each beat to the channel recorded in its tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout         <= '0;
      dout_en      <= '0;
      dout_eop     <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (pop_s) begin
        dout     <= app_rd_data;
        dout_en  <= ch_onehot(pop_tag_s.ch);
        dout_eop <= pop_tag_s.last;
      end else begin
        dout_en  <= '0;
        dout_eop <= 1'b0;
      end
      if (app_rd_data_valid && fifo_empty_s) begin
        rd_underflow <= 1'b1;
      end
    end
  end

  rd_tag_fifo #(
    .DEPTH(MAX_OUT)
  ) u_tag_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_s),
    .wr_data(push_tag_s),
    .pop    (pop_s),
    .rd_data(pop_tag_s),
    .empty  (fifo_empty_s),
    .full   (fifo_full_s),
    .count  (out_cnt_s)
  );

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter with a small in-order DDR read model.
module tb_ddr_rd_arbiter;

  localparam int N_CH       = 16;
  localparam int ADDR_W     = 27;
  localparam int LEN_W      = 27;
  localparam int DATA_W     = 512;
  localparam int APP_ADDR_W = 30;
  localparam int ADDR_SHIFT = 3;
  localparam int MAX_OUT    = 4;

  typedef struct {
    logic [29:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [15:0] en;
    logic        eop;
    logic [31:0] d;
  } beat_t;

  logic                   clk;
  logic                   rst;
  logic                   init_calib_complete;
  logic [N_CH-1:0]        rd_req;
  logic [N_CH*ADDR_W-1:0] rd_start_addr;
  logic [N_CH*LEN_W-1:0]  rd_length;
  logic [N_CH-1:0]        rd_ack;
  logic [APP_ADDR_W-1:0]  app_addr;
  logic [2:0]             app_cmd;
  logic                   app_en;
  logic                   app_rdy;
  logic [DATA_W-1:0]      app_rd_data;
  logic                   app_rd_data_valid;
  logic [DATA_W-1:0]      dout;
  logic [N_CH-1:0]        dout_en;
  logic                   dout_eop;
  logic                   rd_underflow;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          lat;
  int          outst;
  int          max_outst;
  logic        toggle_rdy;
  logic        force_valid;
  logic [29:0] cmd_q[$];
  pend_t       pend_q[$];
  beat_t       beat_q[$];
  logic [15:0] ack_q[$];

  ddr_rd_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
    .APP_ADDR_W(APP_ADDR_W), .ADDR_SHIFT(ADDR_SHIFT), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .rd_req(rd_req), .rd_start_addr(rd_start_addr), .rd_length(rd_length),
    .rd_ack(rd_ack), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .dout(dout), .dout_en(dout_en), .dout_eop(dout_eop), .rd_underflow(rd_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One negedge: observe outputs, drop acked requests, run the DDR model.
  task automatic tick();
    pend_t p;
    @(negedge clk);
    cyc++;
    if (rst) begin
      app_rd_data_valid = 1'b0;
    end else begin
      if (rd_ack != '0) begin
        ack_q.push_back(rd_ack);
        rd_req = rd_req & ~rd_ack;
      end
      if (dout_en != '0) begin
        beat_q.push_back('{dout_en, dout_eop, dout[31:0]});
      end
      app_rdy = toggle_rdy ? ~app_rdy : 1'b1;
      if (app_en && app_rdy) begin
        cmd_q.push_back(app_addr);
        pend_q.push_back('{app_addr, cyc + lat});
        outst++;
        if (outst > max_outst) max_outst = outst;
      end
      app_rd_data_valid = 1'b0;
      if (force_valid) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = {(DATA_W/32){32'hDEAD_BEEF}};
        force_valid       = 1'b0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        app_rd_data_valid = 1'b1;
        app_rd_data       = {(DATA_W/32){{2'b00, p.addr}}};
        outst--;
      end
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    rd_req      = '0;
    force_valid = 1'b0;
    toggle_rdy  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    cmd_q.delete();
    pend_q.delete();
    beat_q.delete();
    ack_q.delete();
    outst     = 0;
    max_outst = 0;
  endtask

  task automatic set_req(input int ch, input logic [26:0] addr, input logic [26:0] len);
    rd_start_addr[ch*ADDR_W +: ADDR_W] = addr;
    rd_length[ch*LEN_W +: LEN_W]       = len;
    rd_req[ch]                         = 1'b1;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && beat_q.size() < n; i++) tick();
    chk(tag, 64'(beat_q.size()), 64'(n));
  endtask

  task automatic check_beats(input string tag, input int n, input logic [15:0] en,
                             input logic [31:0] d0);
    for (int k = 0; k < n && k < beat_q.size(); k++) begin
      chk($sformatf("%s_en%0d", tag, k), beat_q[k].en, en);
      chk($sformatf("%s_eop%0d", tag, k), beat_q[k].eop, (k == n - 1));
      chk($sformatf("%s_d%0d", tag, k), beat_q[k].d, d0 + 32'(8 * k));
    end
  endtask

  task automatic check_cmds(input string tag, input int n, input logic [29:0] a0);
    chk({tag, "_ncmd"}, 64'(cmd_q.size()), 64'(n));
    for (int k = 0; k < n && k < cmd_q.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), cmd_q[k], a0 + 30'(8 * k));
    end
  endtask

  initial begin
    logic [15:0] exp_order[4];
    n_vec = 0; n_err = 0; cyc = 0; lat = 3;
    outst = 0; max_outst = 0;
    init_calib_complete = 1'b0;
    rd_start_addr = '0; rd_length = '0;
    app_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
    do_reset();

    chk("rst_ack", rd_ack, 16'h0000);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_app_addr", app_addr, 30'h0);
    chk("rst_app_cmd", app_cmd, 3'b001);
    chk("rst_dout_en", dout_en, 16'h0000);
    chk("rst_eop", dout_eop, 1'b0);
    chk("rst_uflow", rd_underflow, 1'b0);
    chk("rst_dout", dout[63:0], 64'h0);

    // No grant before calibration completes.
    set_req(4, 27'h10, 27'd1);
    repeat (6) tick();
    chk("calib_block", 64'(ack_q.size()), 64'd0);
    init_calib_complete = 1'b1;
    do_reset();

    // Single channel: ch3, addr 0x100, len 4.
    lat = 3;
    set_req(3, 27'h100, 27'd4);
    tick();
    chk("t1_ack_lat", rd_ack, 16'h0008);
    tick();
    chk("t1_first_en", app_en, 1'b1);
    chk("t1_first_addr", app_addr, 30'h800);
    wait_beats("t1_nbeats", 4, 200);
    check_cmds("t1", 4, 30'h800);
    check_beats("t1", 4, 16'h0008, 32'h800);
    chk("t1_nack", 64'(ack_q.size()), 64'd1);
    chk("t1_en_idle", app_en, 1'b0);

    // Round-robin from rr_ptr 0; ch0 re-requests after ch5 is acked.
    do_reset();
    lat = 2;
    set_req(0, 27'h10, 27'd1);
    set_req(5, 27'h20, 27'd1);
    set_req(15, 27'h30, 27'd1);
    for (int i = 0; i < 50 && ack_q.size() < 2; i++) tick();
    set_req(0, 27'h40, 27'd1);
    wait_beats("t2_nbeats", 4, 200);
    exp_order[0] = 16'h0001; exp_order[1] = 16'h0020;
    exp_order[2] = 16'h8000; exp_order[3] = 16'h0001;
    chk("t2_nack", 64'(ack_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < ack_q.size(); k++) begin
      chk($sformatf("t2_ack%0d", k), ack_q[k], exp_order[k]);
      chk($sformatf("t2_den%0d", k), beat_q[k].en, exp_order[k]);
      chk($sformatf("t2_d%0d", k), beat_q[k].d, 32'h80 * 32'(k + 1));
    end

    // Credit limit: 10 beats at latency 20 with MAX_OUT 4.
    do_reset();
    lat = 20;
    set_req(2, 27'h200, 27'd10);
    wait_beats("t3_nbeats", 10, 600);
    chk("t3_max_out", 64'(max_outst), 64'd4);
    check_cmds("t3", 10, 30'h1000);
    check_beats("t3", 10, 16'h0004, 32'h1000);

    // Backpressure with app_rdy toggling, then a zero-length request.
    do_reset();
    lat = 3;
    toggle_rdy = 1'b1;
    set_req(7, 27'h40, 27'd5);
    wait_beats("t4_nbeats", 5, 300);
    check_cmds("t4", 5, 30'h200);
    check_beats("t4", 5, 16'h0080, 32'h200);
    toggle_rdy = 1'b0;
    set_req(9, 27'h55, 27'd0);
    repeat (12) tick();
    chk("t4_z_nack", 64'(ack_q.size()), 64'd2);
    if (ack_q.size() > 1) chk("t4_z_ack", ack_q[1], 16'h0200);
    chk("t4_z_ncmd", 64'(cmd_q.size()), 64'd5);
    chk("t4_z_nbeat", 64'(beat_q.size()), 64'd5);

    // Address wrap at 2^27 and read-return underflow.
    do_reset();
    set_req(1, 27'h7FF_FFFF, 27'd2);
    wait_beats("t5_nbeats", 2, 200);
    chk("t5_ncmd", 64'(cmd_q.size()), 64'd2);
    if (cmd_q.size() > 1) begin
      chk("t5_addr0", cmd_q[0], 30'h3FFF_FFF8);
      chk("t5_addr1", cmd_q[1], 30'h0);
    end
    if (beat_q.size() > 1) begin
      chk("t5_d0", beat_q[0].d, 32'h3FFF_FFF8);
      chk("t5_eop0", beat_q[0].eop, 1'b0);
      chk("t5_d1", beat_q[1].d, 32'h0);
      chk("t5_eop1", beat_q[1].eop, 1'b1);
      chk("t5_en1", beat_q[1].en, 16'h0002);
    end
    chk("t5_uflow_pre", rd_underflow, 1'b0);
    force_valid = 1'b1;
    tick();
    tick();
    chk("t5_uflow_set", rd_underflow, 1'b1);
    chk("t5_uflow_den", dout_en, 16'h0000);
    repeat (5) tick();
    chk("t5_uflow_sticky", rd_underflow, 1'b1);
    chk("t5_uflow_nbeat", 64'(beat_q.size()), 64'd2);
    do_reset();
    chk("t5_uflow_clr", rd_underflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
